stopwatch_counter: RTL
======================

// Module: stopwatch_counter
// PURPOSE
//  Timekeeping core of the stopwatch. Holds minutes and seconds (0..59 each) in binary.
//  Advances on a 1 Hz tick. Supports pause toggle and an adjust mode that steps one field at 2 Hz.
//  Feeds the digit-separation stage directly: min/sec outputs drive its min/sec inputs.
// PARAMETERS
//  CNT_W    6   width of min/sec fields
//  MAX_SEC  59  last seconds value before wrap to 0
//  MAX_MIN  59  last minutes value before wrap to 0
// PORTS
//  clk        in   1      system clock; all state changes on posedge
//  rst        in   1      asynchronous, active-high reset
//  tick_1hz   in   1      one-clk pulse, 1 Hz; count enable in RUN
//  tick_2hz   in   1      one-clk pulse, 2 Hz; step enable in ADJUST
//  pause_btn  in   1      debounced one-clk pulse; toggles run/pause
//  adj        in   1      level; 1 = adjust mode
//  sel        in   1      level; in ADJUST 0 = step minutes, 1 = step seconds
//  min        out  CNT_W  minutes 0..MAX_MIN
//  sec        out  CNT_W  seconds 0..MAX_SEC
//  paused     out  1      1 when pause flag set
//  adjusting  out  1      1 while state == ADJUST
// BEHAVIOUR
//  Reset (async, any time, incl. mid-adjust): min=0, sec=0, paused=0, adjusting=0, state=RUN.
//  States: RUN, PAUSED, ADJUST. A separate pause flag survives ADJUST.
//  Transitions, evaluated each posedge in priority order:
//   adj==1 -> ADJUST from any state (pause flag kept).
//   ADJUST & adj==0 -> PAUSED if pause flag else RUN.
//   RUN & pause_btn -> PAUSED; PAUSED & pause_btn -> RUN.
//   pause_btn while in ADJUST is ignored; the flag is unchanged.
//  RUN, tick_1hz: if sec<MAX_SEC, sec+1.
//   Else sec=0 and minutes carry: min+1, or min wraps MAX_MIN->0 (59:59 -> 00:00).
//  PAUSED: min/sec hold; ticks ignored.
//  ADJUST, tick_2hz: selected field +1 mod (MAX+1); no carry between fields.
//   The other field holds. tick_1hz is ignored.
//  Same-cycle tick_1hz + pause_btn in RUN: the tick is counted; PAUSED takes effect next cycle.
//  Same-cycle adj rising + tick_1hz: ADJUST wins; the tick is dropped.
//  sel changes take effect on the next tick_2hz; no glitch in the held field.
//  Outputs are registered; update latency is 1 clk after the qualifying tick edge.
//  Arithmetic is unsigned CNT_W-bit. Fields never exceed MAX; compare with ==MAX, not overflow.
//  paused = pause flag; adjusting = (state==ADJUST).
// CONFIGURATION
//  STOPWATCH_ROLLOVER_EN defined:
//   Adds output port rollover (1 bit, reset 0).
//   One-clk pulse on the cycle min/sec become 00:00 via RUN wrap from MAX_MIN:MAX_SEC.
//   No pulse on reset or adjust wraps.
//  Not defined: port and logic absent; wrap behaviour identical.
// STRUCTURE
//  stopwatch_pkg holds:
//   state typedef (RUN/PAUSED/ADJUST)
//   default MAX_SEC/MAX_MIN/CNT_W constants
//   tick-rate constants shared with the clock divider
//  Sub-module sw_field_counter, instantiated twice (sec, min):
//   CNT_W counter, inputs inc and max value, output carry (inc & at max).
//   Wraps to 0 on carry.
//  Top level holds the FSM, pause flag and inc-enable muxing.
// TESTING
//  Reset mid-count at 12:34 -> min=0, sec=0, paused=0, adjusting=0 immediately (async).
//  RUN from 00:58, 2 tick_1hz -> 00:59 then 01:00; from 59:59, 1 tick -> 00:00.
//   With STOPWATCH_ROLLOVER_EN the 59:59 case also gives a rollover pulse of exactly 1 clk.
//  pause_btn, then 5 tick_1hz -> value frozen, paused=1.
//   pause_btn again, 1 tick -> +1 s.
//   Tick and pause_btn in the same cycle -> counted.
//  adj=1, sel=1 at 00:58, 3 tick_2hz -> 00:59, 00:00, 00:01; min stays 0.
//   sel=0, 2 tick_2hz from 59:xx -> 00:xx, 01:xx.
//   tick_1hz during ADJUST -> no change.
//  Pause, then adj=1 then 0 -> returns to PAUSED.
//   Without pause -> returns to RUN.
//   pause_btn during ADJUST -> paused flag unchanged.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch timekeeping path.
// Tick-rate constants are shared with the clock divider that produces tick_1hz/tick_2hz.
package stopwatch_pkg;

    localparam int unsigned DefCntW   = 6;
    localparam int unsigned DefMaxSec = 59;
    localparam int unsigned DefMaxMin = 59;

    localparam int unsigned ClkFreqHz  = 50_000_000;
    localparam int unsigned Tick1HzDiv = ClkFreqHz;
    localparam int unsigned Tick2HzDiv = ClkFreqHz / 2;

    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StPaused = 2'd1,
        StAdjust = 2'd2
    } sw_state_e;

endpackage

// File: rtl/sw_field_counter.sv
// One time field (minutes or seconds): increments on inc_i and wraps to 0 after max_i.
// carry_o flags the increment that wraps, so the next field can chain off it.
module sw_field_counter
    import stopwatch_pkg::*;
#(
    parameter int unsigned CntW = DefCntW
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            inc_i,
    input  logic [CntW-1:0] max_i,
    output logic [CntW-1:0] cnt_o,
    output logic            carry_o
);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            at_max;

    // Equality against max keeps the field in range without relying on binary overflow.
    assign at_max  = (cnt_q == max_i);
    assign carry_o = inc_i & at_max;
    assign cnt_o   = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i) begin
            cnt_d = at_max ? '0 : cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/stopwatch_counter.sv
// Stopwatch timekeeping core: RUN/PAUSED/ADJUST FSM, pause flag and field enables.
// Define STOPWATCH_ROLLOVER_EN to add the rollover_o pulse on a 59:59 -> 00:00 run wrap.
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int unsigned CntW   = DefCntW,
    parameter int unsigned MaxSec = DefMaxSec,
    parameter int unsigned MaxMin = DefMaxMin
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            tick_1hz_i,
    input  logic            tick_2hz_i,
    input  logic            pause_btn_i,
    input  logic            adj_i,
    input  logic            sel_i,
    output logic [CntW-1:0] min_o,
    output logic [CntW-1:0] sec_o,
    output logic            paused_o,
`ifdef STOPWATCH_ROLLOVER_EN
    output logic            rollover_o,
`endif
    output logic            adjusting_o
);

    sw_state_e state_q, state_d;
    logic      pause_q, pause_d;

    logic      run_cnt;
    logic      adj_step;
    logic      sec_inc, min_inc;
    logic      sec_carry, min_carry;

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StRun;
            pause_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pause_q <= pause_d;
        end
    end

    // Next-state: adj has top priority; pause_btn only acts outside ADJUST.
    always_comb begin
        state_d = state_q;
        pause_d = pause_q;
        if (adj_i) begin
            state_d = StAdjust;
        end else begin
            unique case (state_q)
                StAdjust: state_d = pause_q ? StPaused : StRun;
                StRun: begin
                    if (pause_btn_i) begin
                        pause_d = 1'b1;
                        state_d = StPaused;
                    end
                end
                StPaused: begin
                    if (pause_btn_i) begin
                        pause_d = 1'b0;
                        state_d = StRun;
                    end
                end
                default: state_d = StRun;
            endcase
        end
    end

    // Outputs and field enables
    always_comb begin
        run_cnt     = (state_q == StRun) & ~adj_i & tick_1hz_i;
        adj_step    = (state_q == StAdjust) & adj_i & tick_2hz_i;
        sec_inc     = run_cnt | (adj_step & sel_i);
        min_inc     = (run_cnt & sec_carry) | (adj_step & ~sel_i);
        adjusting_o = (state_q == StAdjust);
        paused_o    = pause_q;
    end

    sw_field_counter #(
        .CntW (CntW)
    ) u_sec (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (sec_inc),
        .max_i   (CntW'(MaxSec)),
        .cnt_o   (sec_o),
        .carry_o (sec_carry)
    );

    sw_field_counter #(
        .CntW (CntW)
    ) u_min (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (min_inc),
        .max_i   (CntW'(MaxMin)),
        .cnt_o   (min_o),
        .carry_o (min_carry)
    );

`ifdef STOPWATCH_ROLLOVER_EN
    logic rollover_q, rollover_d;

    // Only a RUN-driven minute carry is a full wrap; adjust wraps never pulse.
    assign rollover_d = run_cnt & min_carry;
    assign rollover_o = rollover_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rollover_q <= 1'b0;
        end else begin
            rollover_q <= rollover_d;
        end
    end
`endif

endmodule
